wb_master: RTL and testbench
============================

WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the bus-cycle limit in wb_clk cycles without wb_ack; 0 disables the timeout.
REQ-002 The block SHALL have parameter ADR_WIDTH, default 1: the width of cmd_adr and wb_adr.
REQ-003 Port wb_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port wb_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port cmd_valid, input, 1 bit: command request.
REQ-006 Port cmd_ready, output, 1 bit: master can accept a command.
REQ-007 Port cmd_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port cmd_adr, input, ADR_WIDTH bits: target address.
REQ-009 Port cmd_dat, input, 32 bits: write data.
REQ-010 Port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 Port rsp_err, output, 1 bit: the completed command timed out.
REQ-012 Port rsp_dat, output, 32 bits: read data.
REQ-013 Port busy, output, 1 bit: a bus cycle is in progress.
REQ-014 Port wb_cyc, output, 1 bit: Wishbone cycle.
REQ-015 Port wb_stb, output, 1 bit: Wishbone strobe.
REQ-016 Port wb_we, output, 1 bit: Wishbone write enable.
REQ-017 Port wb_adr, output, ADR_WIDTH bits: Wishbone address.
REQ-018 Port wb_dat_o, output, 32 bits: Wishbone write data.
REQ-019 Port wb_dat_i, input, 32 bits: Wishbone read data.
REQ-020 Port wb_ack, input, 1 bit: Wishbone acknowledge.

Function
REQ-021 The block SHALL implement exactly two states, IDLE and BUS.
REQ-022 In IDLE, cmd_ready SHALL be 1 and busy, wb_cyc and wb_stb SHALL be 0; in BUS, cmd_ready SHALL be 0 and busy, wb_cyc and wb_stb SHALL be 1.
REQ-023 On an edge with IDLE and cmd_valid=1, the block SHALL register cmd_we, cmd_adr and cmd_dat into wb_we, wb_adr and wb_dat_o, clear the timeout counter, and enter BUS.
REQ-024 wb_cyc and wb_stb SHALL be registered outputs; they SHALL assert on the edge after acceptance (acceptance edge N, asserted from N+1).
REQ-025 wb_we, wb_adr and wb_dat_o SHALL remain stable throughout BUS.
REQ-026 On an edge in BUS with wb_ack=1, the block SHALL:
 - return to IDLE, deasserting wb_cyc and wb_stb;
 - pulse rsp_valid for one cycle with rsp_err=0;
 - load rsp_dat with wb_dat_i for a read, or with 0 for a write.
REQ-027 In BUS with wb_ack=0, the timeout counter SHALL increment each cycle; its width SHALL be clog2(TIMEOUT+1), minimum 1 bit.
REQ-028 When TIMEOUT is nonzero, the counter equals TIMEOUT-1 and wb_ack=0 on an edge, the block SHALL abort: return to IDLE, pulse rsp_valid with rsp_err=1, and set rsp_dat=0.
 - A Wishbone cycle therefore lasts at most TIMEOUT cycles.
REQ-029 If wb_ack=1 on the same edge the timeout would fire, the ack SHALL win and rsp_err SHALL be 0.
REQ-030 wb_ack sampled in IDLE SHALL be ignored and SHALL NOT produce rsp_valid.
REQ-031 A new command SHALL be acceptable on the cycle after completion, which guarantees at least one cycle with wb_stb=0 between consecutive bus cycles.
REQ-032 rsp_dat and rsp_err SHALL hold their values until the next completion.
REQ-033 cmd_valid SHALL be ignored while in BUS; no command queueing.

Reset
REQ-034 When wb_rst_n=0, the block SHALL immediately (asynchronously) force state IDLE, with:
 - wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err and busy = 0;
 - wb_adr, wb_dat_o, rsp_dat and the counter = 0.
REQ-035 A reset asserted in BUS SHALL abort the bus cycle without producing rsp_valid.
REQ-036 The first command SHALL be acceptable on the first rising edge with wb_rst_n=1.

Verification
REQ-037 Write: cmd we=1, adr=1, dat=0x12345678, slave acks on the 2nd strobe cycle -> wb_cyc=1 for 2 cycles with wb_dat_o=0x12345678; rsp_valid for 1 cycle, rsp_err=0, rsp_dat=0.
REQ-038 Read: slave holds 0xCAFEF00D at adr 1; cmd we=0, adr=1 -> rsp_valid with rsp_dat=0xCAFEF00D and rsp_err=0.
REQ-039 Timeout: TIMEOUT=4, slave never acks -> wb_cyc high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
REQ-040 Race: TIMEOUT=4, ack in the 4th strobe cycle with wb_dat_i=0xA5A5A5A5 -> rsp_err=0, rsp_dat=0xA5A5A5A5.
REQ-041 Back-to-back: cmd_valid held high for 3 commands -> 3 responses, wb_stb low for at least 1 cycle between cycles; a stray wb_ack in IDLE produces no response.
REQ-042 Reset mid-cycle: wb_rst_n=0 in the 2nd BUS cycle -> wb_cyc=0 before the next edge, no rsp_valid; after release, a read completes normally.

Source files
------------

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic master with an ack timeout.
// Ports:
//   wb_clk, wb_rst_n              clock and asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_we/cmd_adr/cmd_dat carry the command
//   rsp_valid/rsp_err/rsp_dat     one-cycle completion pulse, timeout flag, read data
//   busy                          a bus cycle is in progress
//   wb_cyc/wb_stb/wb_we/wb_adr/wb_dat_o/wb_dat_i/wb_ack   Wishbone master side
module wb_master #(
    parameter int TIMEOUT   = 255,
    parameter int ADR_WIDTH = 1
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_WIDTH-1:0] cmd_adr,
    input  logic [31:0]          cmd_dat,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [31:0]          rsp_dat,
    output logic                 busy,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [ADR_WIDTH-1:0] wb_adr,
    output logic [31:0]          wb_dat_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack
);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TL = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LAST = TL[CW-1:0];

    typedef enum logic {IDLE, BUS} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          w_accept, w_done_ack, w_timeout;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // Handshake and bus strobes decode straight from the one-bit state register,
    // so wb_cyc/wb_stb are glitch-free and rise on the edge after acceptance.
    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        wb_cyc     = 1'b0;
        wb_stb     = 1'b0;
        w_accept   = 1'b0;
        w_done_ack = 1'b0;
        w_timeout  = 1'b0;
        if (r_state == IDLE) begin
            cmd_ready = 1'b1;
            w_accept  = cmd_valid;
            w_next    = cmd_valid ? BUS : IDLE;
        end else begin
            busy       = 1'b1;
            wb_cyc     = 1'b1;
            wb_stb     = 1'b1;
            w_done_ack = wb_ack;
            // ack on the limit cycle takes priority over the timeout
            w_timeout  = (TIMEOUT != 0) && !wb_ack && (r_cnt == CNT_LAST);
            w_next     = (w_done_ack || w_timeout) ? IDLE : BUS;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_we     <= 1'b0;
            wb_adr    <= '0;
            wb_dat_o  <= '0;
            r_cnt     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            rsp_valid <= w_done_ack | w_timeout;
            if (w_accept) begin
                wb_we    <= cmd_we;
                wb_adr   <= cmd_adr;
                wb_dat_o <= cmd_dat;
                r_cnt    <= '0;
            end else if (r_state == BUS && !wb_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done_ack) begin
                rsp_err <= 1'b0;
                rsp_dat <= wb_we ? 32'd0 : wb_dat_i;
            end else if (w_timeout) begin
                rsp_err <= 1'b1;
                rsp_dat <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed self-checking bench for wb_master (TIMEOUT=4, ADR_WIDTH=1).
module tb_wb_master;
    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [0:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    logic        busy;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [0:0]  wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;

    int total = 0;
    int bad = 0;

    wb_master #(.TIMEOUT(4), .ADR_WIDTH(1)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_dat(rsp_dat), .busy(busy),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    // Issue one command and act as slave: ack in strobe cycle ack_at (0 = never).
    // Returns the number of sampled cycles with wb_cyc high.
    task automatic do_cmd(input logic we, input logic adr, input logic [31:0] dat,
                          input int ack_at, input logic [31:0] rd, output int n);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        step();
        cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && wb_cyc; i++) begin
            n++;
            chk("bus_dat", wb_dat_o, dat);
            chk("bus_we_adr", {30'd0, wb_we, wb_adr}, {30'd0, we, adr});
            chk("bus_ready", {30'd0, cmd_ready, busy}, 32'd1);
            wb_ack   = (n == ack_at);
            wb_dat_i = wb_ack ? rd : 32'hDEADBEEF;
            step();
        end
        wb_ack = 1'b0;
        chk("cyc_bounded", {31'd0, wb_cyc}, 32'd0);
    endtask

    initial begin
        int n, starts, resps, adj;
        logic prev_stb;
        // reset state
        #12;
        chk("rst_ctl", {26'd0, cmd_ready, busy, wb_cyc, wb_stb, wb_we, rsp_valid}, 32'b100000);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_adr_dat", {31'd0, wb_adr} | wb_dat_o | rsp_dat, 32'd0);
        @(posedge wb_clk);
        #1 wb_rst_n = 1'b1;

        // write, ack on 2nd strobe cycle
        do_cmd(1'b1, 1'b1, 32'h12345678, 2, 32'h0BADF00D, n);
        chk("wr_len", n, 32'd2);
        chk("wr_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
        chk("wr_dat", rsp_dat, 32'd0);
        chk("wr_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        chk("wr_pulse", {31'd0, rsp_valid}, 32'd0);

        // read
        do_cmd(1'b0, 1'b1, 32'h0, 1, 32'hCAFEF00D, n);
        chk("rd_len", n, 32'd1);
        chk("rd_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
        chk("rd_dat", rsp_dat, 32'hCAFEF00D);
        step();
        chk("rd_hold", rsp_dat, 32'hCAFEF00D);

        // timeout
        do_cmd(1'b0, 1'b0, 32'h0, 0, 32'h0, n);
        chk("to_len", n, 32'd4);
        chk("to_rsp", {30'd0, rsp_valid, rsp_err}, 32'b11);
        chk("to_dat", rsp_dat, 32'd0);
        step();
        chk("to_hold", {30'd0, rsp_valid, rsp_err}, 32'b01);

        // race: ack on the limit cycle wins
        do_cmd(1'b0, 1'b1, 32'h0, 4, 32'hA5A5A5A5, n);
        chk("race_len", n, 32'd4);
        chk("race_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
        chk("race_dat", rsp_dat, 32'hA5A5A5A5);
        step();

        // back-to-back with cmd_valid held high, slave acks immediately
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_adr = 1'b1;
        starts = 0;
        resps = 0;
        adj = 0;
        prev_stb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) begin
                resps++;
                chk("b2b_dat", rsp_dat, 32'h100 + resps);
            end
            if (wb_stb) begin
                starts++;
                if (prev_stb) adj++;
                if (starts == 3) cmd_valid = 1'b0;
            end
            prev_stb = wb_stb;
            wb_ack   = wb_stb;
            wb_dat_i = 32'h100 + starts;
        end
        wb_ack = 1'b0;
        chk("b2b_starts", starts, 32'd3);
        chk("b2b_resps", resps, 32'd3);
        chk("b2b_gap", adj, 32'd0);

        // stray ack in IDLE
        wb_ack = 1'b1;
        step();
        step();
        chk("stray", {30'd0, rsp_valid, wb_cyc}, 32'd0);
        wb_ack = 1'b0;

        // reset in 2nd bus cycle
        cmd_valid = 1'b1;
        cmd_we = 1'b1;
        cmd_adr = 1'b1;
        cmd_dat = 32'h55AA55AA;
        step();
        cmd_valid = 1'b0;
        chk("mr_cyc1", {31'd0, wb_cyc}, 32'd1);
        step();
        chk("mr_cyc2", wb_dat_o, 32'h55AA55AA);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("mr_async", {27'd0, cmd_ready, busy, wb_cyc, wb_stb, rsp_valid}, 32'b10000);
        chk("mr_clr", {31'd0, wb_adr} | wb_dat_o | rsp_dat, 32'd0);
        step();
        chk("mr_norsp", {31'd0, rsp_valid}, 32'd0);
        // release and issue the first command immediately
        wb_rst_n = 1'b1;
        do_cmd(1'b0, 1'b1, 32'h0, 2, 32'h600DCAFE, n);
        chk("post_len", n, 32'd2);
        chk("post_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
        chk("post_dat", rsp_dat, 32'h600DCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
